param_dcache: RTL and testbench
===============================

Name: param_dcache

Overview:
Parametrised write-back, set-associative data cache with true-LRU replacement. It sits between the datapath's data request port and the cache controller/memory arbiter. It generalises the fixed 8-set, 2-way, 2-word data cache in three ways: configurable geometry, multi-word burst write-back and fill, and a halt-time flush with hit/miss statistics.

Parameters:
SETS, 8, number of sets; power of 2, at least 2.
WAYS, 2, associativity; power of 2, at least 1.
WORDS, 2, 32-bit words per block; power of 2, at least 1.
CNT_W, 32, width of the hit and miss counters.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
dmemREN  in  1  datapath read request.
dmemWEN  in  1  datapath write request; never asserted together with dmemREN.
dmemaddr  in  32  byte address; bits [1:0] ignored.
dmemstore  in  32  write data.
halt  in  1  processor halted; level-sensitive request to flush.
dhit  out  1  request serviced this cycle.
dmemload  out  32  read data; valid while dhit=1 on a read.
flushed  out  1  flush complete; sticky until reset.
dREN  out  1  memory read request.
dWEN  out  1  memory write request.
daddr  out  32  memory word address.
dstore  out  32  memory write data.
dload  in  32  memory read data; valid when dwait=0.
dwait  in  1  memory busy; a transfer completes on a cycle with dwait=0.
hit_count  out  CNT_W  number of requests that hit.
miss_count  out  CNT_W  number of misses.

Behaviour:
- Address split: blkoff = addr[2+:log2(WORDS)]; idx = next log2(SETS) bits; tag = remaining upper bits.
- Per set and way: valid, dirty, tag, WORDS data words, and a log2(WAYS)-bit LRU age.
- Reset: all valid, dirty and age bits = 0; counters = 0; state = IDLE. All outputs are 0. Reset asserted mid-burst drops dREN/dWEN immediately.
- States: IDLE, WB, FILL, FLUSH, DONE.
- IDLE with request and tag match in a valid way:
  - dhit=1 combinationally in the same cycle.
  - Read: dmemload = the selected word.
  - Write: word written at the clock edge; dirty set.
  - LRU updates: accessed way age=0; every way with a smaller age increments.
- IDLE with request and miss:
  - miss_count increments.
  - Victim = lowest-index invalid way, else the way with age = WAYS-1.
  - Next state is WB if the victim is valid and dirty, else FILL.
  - dhit=0.
- WB:
  - dWEN=1, daddr = {victim tag, idx, k, 2'b00}, dstore = victim word k, with k starting at 0.
  - k advances when dwait=0.
  - After word WORDS-1 completes, go to FILL with k=0.
- FILL:
  - dREN=1, daddr = {request tag, idx, k, 2'b00}.
  - On dwait=0, dload is written into the victim word k and k advances.
  - After the last word: tag written, valid=1, dirty=0, LRU updated as an access, return to IDLE.
  - The request then hits in IDLE on the following cycle.
- hit_count increments on dhit cycles, except the first dhit after a fill. The miss already counted that request.
- dREN/dWEN are held stable until dwait=0. Requests are ignored outside IDLE; the datapath holds them stable.
- halt:
  - In IDLE, halt has priority over any request and the cache enters FLUSH.
  - halt seen during WB/FILL is taken at the next return to IDLE.
- FLUSH:
  - Scans set 0..SETS-1 and way 0..WAYS-1.
  - For each dirty valid line, writes WORDS words exactly as in WB.
  - Clean or invalid lines take one cycle each.
  - Every line is invalidated after it is visited.
  - After the last line, go to DONE.
- DONE: flushed=1, dREN=dWEN=0, dhit=0; remains here until reset.
- Counters wrap at 2^CNT_W.
- WAYS=1: LRU is unused and the victim is always way 0.
- WORDS=1: bursts are a single word.

Test Plan:
- Reset, then read 0x100 with dwait=0 each cycle -> miss_count=1. FILL issues daddr 0x100, 0x104. dhit=1 in the cycle after FILL with dmemload = dload captured at 0x100; hit_count=0.
- Write 0xDEADBEEF to 0x104 after the fill above -> dhit same cycle. A following read of 0x104 returns 0xDEADBEEF; hit_count=2.
- Defaults, fill three tags into set 0 (0x000, 0x040, 0x080) after writing 0x000 -> 0x000 is the LRU and dirty. The third miss performs WB at 0x000, 0x004 with the written data, then FILL at 0x080.
- During FILL, hold dwait=1 for 5 cycles per word -> daddr and dREN stay stable. The fill completes only after the two dwait=0 cycles.
- Dirty lines in sets 2 and 5, then assert halt -> exactly 2×WORDS write-backs in set order, then flushed=1. A later dmemREN gives dhit=0 and no memory traffic.
- Assert nRST low mid-WB -> dWEN=0 immediately. After release, a read of the previously resident address misses.

Source files
------------

// File: rtl/param_dcache.sv
// Write-back set-associative data cache with true-LRU, burst write-back/fill and a halt-time flush.
// Hits answer combinationally in IDLE; misses hold dhit low while dwait paces each memory word.
module param_dcache #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic [31:0]      dmemaddr,
  input  logic [31:0]      dmemstore,
  input  logic             halt,
  output logic             dhit,
  output logic [31:0]      dmemload,
  output logic             flushed,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  input  logic [31:0]      dload,
  input  logic             dwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int OB    = $clog2(WORDS);
  localparam int IB    = $clog2(SETS);
  localparam int TAG_W = 30 - OB - IB;
  localparam int OFF_W = (WORDS > 1) ? OB : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, DONE} state_t;

  state_t             state;
  logic               valid [SETS][WAYS];
  logic               dirty [SETS][WAYS];
  logic [WAY_W-1:0]   age   [SETS][WAYS];
  logic [TAG_W-1:0]   tags  [SETS][WAYS];
  logic [31:0]        data  [SETS][WAYS][WORDS];

  logic [OFF_W-1:0]   k;
  logic [WAY_W-1:0]   vway, fway;
  logic [IB-1:0]      midx, fset;
  logic [TAG_W-1:0]   mtag;
  logic               halt_pend, skip_hit;

  logic [OFF_W-1:0]   rblk;
  logic [IB-1:0]      ridx, lru_set;
  logic [TAG_W-1:0]   rtag;
  logic               req, hit, found, halt_eff, fline, last_beat, fill_beat, fill_done, lru_en;
  logic [WAY_W-1:0]   hway, vway_c, lru_way, lru_ref;

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t, input logic [IB-1:0] i,
                                          input logic [OFF_W-1:0] w);
    return (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB)) | (32'(w) << 2);
  endfunction

  assign rblk = OFF_W'((dmemaddr >> 2) & 32'(WORDS - 1));
  assign ridx = IB'(dmemaddr >> (2 + OB));
  assign rtag = TAG_W'(dmemaddr >> (2 + OB + IB));

  always_comb begin
    hit = 1'b0;
    hway = '0;
    found = 1'b0;
    vway_c = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[ridx][w] && tags[ridx][w] == rtag) begin
        hit = 1'b1;
        hway = WAY_W'(w);
      end
    // Downward scan leaves the lowest-index invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[ridx][w]) begin
        found = 1'b1;
        vway_c = WAY_W'(w);
      end
    if (!found)
      for (int w = 0; w < WAYS; w++)
        if (age[ridx][w] == WAY_W'(WAYS - 1)) vway_c = WAY_W'(w);
  end

  assign req       = dmemREN | dmemWEN;
  assign halt_eff  = halt | halt_pend;
  assign dhit      = (state == IDLE) && !halt_eff && req && hit;
  assign dmemload  = (dhit && dmemREN) ? data[ridx][hway][rblk] : '0;
  assign flushed   = (state == DONE);
  assign fline     = valid[fset][fway] && dirty[fset][fway];
  assign dREN      = (state == FILL);
  assign dWEN      = (state == WB) || (state == FLUSH && fline);
  assign last_beat = (k == OFF_W'(WORDS - 1));
  assign fill_beat = (state == FILL) && !dwait;
  assign fill_done = fill_beat && last_beat;

  // A freshly filled way counts as previously oldest so every valid way ages past it.
  assign lru_en  = dhit || fill_done;
  assign lru_set = (state == FILL) ? midx : ridx;
  assign lru_way = (state == FILL) ? vway : hway;
  assign lru_ref = (state == FILL && !valid[midx][vway]) ? WAY_W'(WAYS - 1) : age[lru_set][lru_way];

  always_comb begin
    daddr  = '0;
    dstore = '0;
    case (state)
      WB: begin
        daddr  = mk_addr(tags[midx][vway], midx, k);
        dstore = data[midx][vway][k];
      end
      FILL: daddr = mk_addr(mtag, midx, k);
      FLUSH:
        if (fline) begin
          daddr  = mk_addr(tags[fset][fway], fset, k);
          dstore = data[fset][fway][k];
        end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      k          <= '0;
      vway       <= '0;
      fway       <= '0;
      midx       <= '0;
      fset       <= '0;
      mtag       <= '0;
      halt_pend  <= 1'b0;
      skip_hit   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= '0;
        end
    end else begin
      if (halt && state != IDLE) halt_pend <= 1'b1;
      if (lru_en)
        for (int j = 0; j < WAYS; j++)
          if (WAY_W'(j) == lru_way) age[lru_set][j] <= '0;
          else if (valid[lru_set][j] && age[lru_set][j] < lru_ref)
            age[lru_set][j] <= age[lru_set][j] + 1'b1;
      case (state)
        IDLE:
          if (halt_eff) begin
            state <= FLUSH;
            fset  <= '0;
            fway  <= '0;
            k     <= '0;
          end else if (req) begin
            if (hit) begin
              // The miss already counted the request that a fill just completed.
              if (skip_hit) skip_hit <= 1'b0;
              else hit_count <= hit_count + 1'b1;
              if (dmemWEN) dirty[ridx][hway] <= 1'b1;
            end else begin
              miss_count <= miss_count + 1'b1;
              vway  <= vway_c;
              midx  <= ridx;
              mtag  <= rtag;
              k     <= '0;
              state <= (valid[ridx][vway_c] && dirty[ridx][vway_c]) ? WB : FILL;
            end
          end
        WB:
          if (!dwait) begin
            k <= last_beat ? '0 : k + 1'b1;
            if (last_beat) state <= FILL;
          end
        FILL:
          if (!dwait) begin
            k <= last_beat ? '0 : k + 1'b1;
            if (last_beat) begin
              valid[midx][vway] <= 1'b1;
              dirty[midx][vway] <= 1'b0;
              skip_hit          <= 1'b1;
              state             <= IDLE;
            end
          end
        FLUSH: begin
          if (fline && !dwait) k <= last_beat ? '0 : k + 1'b1;
          if (!fline || (!dwait && last_beat)) begin
            valid[fset][fway] <= 1'b0;
            dirty[fset][fway] <= 1'b0;
            if (fway == WAY_W'(WAYS - 1)) begin
              fway <= '0;
              if (fset == IB'(SETS - 1)) state <= DONE;
              else fset <= fset + 1'b1;
            end else begin
              fway <= fway + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (dhit && dmemWEN) data[ridx][hway][rblk] <= dmemstore;
    if (fill_beat) data[midx][vway][k] <= dload;
    if (fill_done) tags[midx][vway] <= mtag;
  end
endmodule

// File: tb/tb_param_dcache.sv
// Directed bench for param_dcache (default geometry) against a simple word-addressed memory model.
module tb_param_dcache;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0, dload;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore, hit_count, miss_count;

  param_dcache dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // Untouched memory words read back as 0xA0000000 | address.
  bit [31:0]   mem [256];
  bit          mw  [256];
  logic [31:0] wb_a[$], wb_d[$], rd_a[$];

  always_comb dload = mw[daddr[9:2]] ? mem[daddr[9:2]] : (32'hA000_0000 | daddr);

  always @(posedge CLK)
    if (nRST) begin
      if (dWEN && !dwait) begin
        mem[daddr[9:2]] <= dstore;
        mw[daddr[9:2]]  <= 1'b1;
        wb_a.push_back(daddr);
        wb_d.push_back(dstore);
      end
      if (dREN && !dwait) rd_a.push_back(daddr);
    end

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dwait = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    if (check) begin
      chk("rst_dhit", 32'(dhit), 0);
      chk("rst_dren_dwen", {30'd0, dREN, dWEN}, 0);
      chk("rst_daddr", daddr, 0);
      chk("rst_flushed", 32'(flushed), 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
    end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Holds a request until dhit; cyc counts the cycles spent waiting.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ld, output int cyc);
    dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
    cyc = 0; ld = '0;
    while (1) begin
      @(negedge CLK);
      if (dhit) begin
        ld = dmemload;
        break;
      end
      cyc++;
      if (cyc > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL access_timeout: addr %h got no dhit, required dhit within 200 cycles", a);
        break;
      end
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_ld;
    int          exp_cyc;
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    vec_t        v [9];
    logic [31:0] ld;
    int          cyc, base;
    bit          ok;

    v[0] = '{1'b0, 1'b0, 32'h100, 32'h0,         32'hA000_0100, 3, 32'd0, 32'd1};
    v[1] = '{1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 32'h0,         0, 32'd1, 32'd1};
    v[2] = '{1'b0, 1'b0, 32'h104, 32'h0,         32'hDEAD_BEEF, 0, 32'd2, 32'd1};
    v[3] = '{1'b0, 1'b0, 32'h100, 32'h0,         32'hA000_0100, 0, 32'd3, 32'd1};
    v[4] = '{1'b1, 1'b1, 32'h000, 32'h1111_1111, 32'h0,         3, 32'd0, 32'd1};
    v[5] = '{1'b0, 1'b1, 32'h004, 32'h2222_2222, 32'h0,         0, 32'd1, 32'd1};
    v[6] = '{1'b0, 1'b0, 32'h040, 32'h0,         32'hA000_0040, 3, 32'd1, 32'd2};
    v[7] = '{1'b0, 1'b0, 32'h080, 32'h0,         32'hA000_0080, 5, 32'd1, 32'd3};
    v[8] = '{1'b0, 1'b0, 32'h000, 32'h0,         32'h1111_1111, 3, 32'd1, 32'd4};

    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      if (v[i].rst) do_reset(1'b0);
      access(v[i].wr, v[i].addr, v[i].data, ld, cyc);
      if (!v[i].wr) chk($sformatf("v%0d_load", i), ld, v[i].exp_ld);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(v[i].exp_cyc));
      chk($sformatf("v%0d_hit_count", i), hit_count, v[i].exp_hit);
      chk($sformatf("v%0d_miss_count", i), miss_count, v[i].exp_miss);
    end
    chk("fill_rd_count", 32'(rd_a.size() >= 2), 1);
    if (rd_a.size() >= 2) begin
      chk("fill_addr0", rd_a[0], 32'h100);
      chk("fill_addr1", rd_a[1], 32'h104);
    end
    chk("wb_count", 32'(wb_a.size()), 2);
    if (wb_a.size() == 2) begin
      chk("wb_addr0", wb_a[0], 32'h000);
      chk("wb_data0", wb_d[0], 32'h1111_1111);
      chk("wb_addr1", wb_a[1], 32'h004);
      chk("wb_data1", wb_d[1], 32'h2222_2222);
    end

    // Fill paced by dwait: five busy cycles per word, address and dREN held.
    dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h0C0;
    @(negedge CLK);
    chk("stall_miss_dhit", 32'(dhit), 0);
    ok = 1'b1;
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 6; c++) begin
        @(negedge CLK);
        if (!dREN || dhit || daddr != 32'h0C0 + 32'(4 * w)) ok = 1'b0;
        if (c == 5) begin
          dwait = 1'b0;
          @(posedge CLK); #1;
          dwait = (w == 0);
        end
      end
    @(negedge CLK);
    chk("stall_hold_ok", 32'(ok), 1);
    chk("stall_dhit", 32'(dhit), 1);
    chk("stall_load", dmemload, 32'hA000_00C0);
    @(posedge CLK); #1;
    dmemREN = 1'b0;
    chk("stall_miss_count", miss_count, 5);

    // Halt-time flush of dirty lines in sets 2 and 5.
    do_reset(1'b0);
    access(1'b1, 32'h010, 32'h0000_0055, ld, cyc);
    access(1'b1, 32'h028, 32'h0000_0066, ld, cyc);
    chk("flush_pre_hits", hit_count, 0);
    chk("flush_pre_flushed", 32'(flushed), 0);
    base = wb_a.size();
    halt = 1'b1;
    cyc = 0;
    while (!flushed && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    chk("flush_done", 32'(flushed), 1);
    chk("flush_wb_count", 32'(wb_a.size() - base), 4);
    if (wb_a.size() - base == 4) begin
      chk("flush_a0", wb_a[base],     32'h010);
      chk("flush_d0", wb_d[base],     32'h0000_0055);
      chk("flush_a1", wb_a[base + 1], 32'h014);
      chk("flush_d1", wb_d[base + 1], 32'hA000_0014);
      chk("flush_a2", wb_a[base + 2], 32'h028);
      chk("flush_d2", wb_d[base + 2], 32'h0000_0066);
      chk("flush_a3", wb_a[base + 3], 32'h02C);
      chk("flush_d3", wb_d[base + 3], 32'hA000_002C);
    end
    @(posedge CLK); #1;
    halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h010;
    ok = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (dhit || dREN || dWEN || !flushed) ok = 1'b0;
    end
    chk("done_quiet", 32'(ok), 1);
    @(posedge CLK); #1;
    dmemREN = 1'b0;

    // Reset in the middle of a stalled write-back.
    do_reset(1'b0);
    access(1'b1, 32'h000, 32'h0000_0077, ld, cyc);
    access(1'b0, 32'h040, 32'h0, ld, cyc);
    dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h080;
    @(negedge CLK);
    @(negedge CLK);
    chk("midwb_dwen", 32'(dWEN), 1);
    chk("midwb_daddr", daddr, 32'h000);
    chk("midwb_dstore", dstore, 32'h0000_0077);
    nRST = 1'b0;
    #1;
    chk("midwb_rst_dwen", 32'(dWEN), 0);
    chk("midwb_rst_daddr", daddr, 0);
    dmemREN = 1'b0; dwait = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    access(1'b0, 32'h000, 32'h0, ld, cyc);
    chk("postrst_cycles", 32'(cyc), 3);
    chk("postrst_load", ld, 32'h1111_1111);
    chk("postrst_miss_count", miss_count, 1);
    chk("postrst_hit_count", hit_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
